// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined parametrised FP multiplier with flush-to-zero, five rounding modes and valid/ready flow control
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+FRC_W:0] fp_X,
    input  logic [EXP_W+FRC_W:0] fp_Y,
    input  logic [2:0]           r_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+FRC_W:0] fp_Z,
    output logic                 ovrf,
    output logic                 udrf
);
    localparam int W = 1 + EXP_W + FRC_W;
    localparam int P = 2 * FRC_W + 2;
    localparam int E = EXP_W + 2;
    localparam logic [EXP_W-1:0] EONES = '1;
    localparam logic [EXP_W-1:0] EMAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [E-1:0] BIAS = E'((1 << (EXP_W - 1)) - 1);

    logic adv, v0, v1, v2;
    logic [W-1:0] x0, y0;
    logic [2:0] m0, m1, m2;
    logic s1, nan1, inf1, zer1, s2, nan2, inf2, zer2;
    logic [P-1:0] prod1;
    logic [E-1:0] exp1, exp2;
    logic [FRC_W-1:0] frc2;

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;

    // S1: classify the registered operands
    logic [EXP_W-1:0] ex, ey;
    logic [FRC_W-1:0] fx, fy;
    logic x_z, y_z, x_i, y_i, x_n, y_n;
    assign ex = x0[W-2 -: EXP_W];
    assign ey = y0[W-2 -: EXP_W];
    assign fx = x0[FRC_W-1:0];
    assign fy = y0[FRC_W-1:0];
    assign x_z = ex == '0;
    assign y_z = ey == '0;
    assign x_i = ex == EONES && fx == '0;
    assign y_i = ey == EONES && fy == '0;
    assign x_n = ex == EONES && fx != '0;
    assign y_n = ey == EONES && fy != '0;

    // S2: normalise, guard/sticky, rounding increment
    logic norm, grd, stk, inc;
    logic [FRC_W-1:0] frc;
    logic [FRC_W:0] rnd;
    assign norm = prod1[P-1];
    assign frc = norm ? prod1[P-2 -: FRC_W] : prod1[P-3 -: FRC_W];
    assign grd = norm ? prod1[FRC_W] : prod1[FRC_W-1];
    assign stk = norm ? |prod1[FRC_W-1:0] : |prod1[FRC_W-2:0];
    assign inc = m1 == 3'd1 ? 1'b0 :
                 m1 == 3'd2 ? s1 & (grd | stk) :
                 m1 == 3'd3 ? !s1 & (grd | stk) :
                 m1 == 3'd4 ? grd : grd & (stk | frc[0]);
    assign rnd = {1'b0, frc} + {{FRC_W{1'b0}}, inc};

    // S3: range checks and special-value selection
    logic ovf, unf, spec, to_max;
    logic [W-1:0] z_n;
    assign ovf = !exp2[E-1] && exp2[E-2:0] >= {1'b0, EONES};
    assign unf = exp2[E-1] || exp2 == '0;
    assign spec = nan2 || inf2 || zer2;
    assign to_max = m2 == 3'd1 || (m2 == 3'd2 && !s2) || (m2 == 3'd3 && s2);
    assign z_n = nan2 ? {1'b0, EONES, 1'b1, {(FRC_W-1){1'b0}}} :
                 inf2 ? {s2, EONES, {FRC_W{1'b0}}} :
                 zer2 ? {s2, {(W-1){1'b0}}} :
                 ovf ? (to_max ? {s2, EMAXF, {FRC_W{1'b1}}} : {s2, EONES, {FRC_W{1'b0}}}) :
                 unf ? {s2, {(W-1){1'b0}}} : {s2, exp2[EXP_W-1:0], frc2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v0, v1, v2, out_valid} <= '0;
            fp_Z <= '0;
            ovrf <= 1'b0;
            udrf <= 1'b0;
        end else if (adv) begin
            v0 <= in_valid;
            v1 <= v0;
            v2 <= v1;
            out_valid <= v2;
            fp_Z <= z_n;
            ovrf <= !spec && ovf;
            udrf <= !spec && !ovf && unf;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            x0 <= fp_X;
            y0 <= fp_Y;
            m0 <= r_mode;
            s1 <= x0[W-1] ^ y0[W-1];
            nan1 <= x_n || y_n || (x_i && y_z) || (y_i && x_z);
            inf1 <= x_i || y_i;
            zer1 <= x_z || y_z;
            prod1 <= P'({1'b1, fx}) * P'({1'b1, fy});
            exp1 <= {2'b00, ex} + {2'b00, ey} - BIAS;
            m1 <= m0;
            s2 <= s1;
            nan2 <= nan1;
            inf2 <= inf1;
            zer2 <= zer1;
            exp2 <= exp1 + E'(norm) + E'(rnd[FRC_W]);
            frc2 <= rnd[FRC_W-1:0];
            m2 <= m1;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: random and directed checks of fp_mul_pipe against an integer-arithmetic rounding model
module tb_fp_mul_pipe;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic in_valid = 0, out_ready = 0, in_ready, out_valid, ovrf, udrf;
    logic [31:0] fp_X = 0, fp_Y = 0, fp_Z;
    logic [2:0] r_mode = 0;
    logic h_iv = 0, h_or = 1, h_ir, h_ov, h_ovf, h_udf;
    logic [15:0] h_x = 0, h_y = 0, h_z;
    logic [2:0] h_m = 0;

    fp_mul_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid), .out_ready(out_ready),
        .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf));
    fp_mul_pipe #(.EXP_W(5), .FRC_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .in_valid(h_iv),
        .in_ready(h_ir), .fp_X(h_x), .fp_Y(h_y), .r_mode(h_m), .out_valid(h_ov), .out_ready(h_or),
        .fp_Z(h_z), .ovrf(h_ovf), .udrf(h_udf));

    typedef struct {bit [63:0] z; bit ov; bit un;} res_t;
    res_t sb[$];
    res_t dir_e;
    bit use_dir = 0, was_stall = 0;
    bit [33:0] held;
    int n_chk = 0, n_pass = 0, n_ret = 0, n_stall = 0;

    task automatic chk(input string tag, input bit [63:0] got, input bit [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Exact product, then round by comparing the discarded remainder with one half ulp
    function automatic res_t ref_mul(bit [63:0] x, bit [63:0] y, bit [2:0] m, int ew, int fw);
        res_t r;
        bit [63:0] one = 1, fm, em, ex, ey, fx, fy, p, q, rem, half, sg;
        bit s, up, xz, yz, xi, yi, xn, yn, to_max;
        longint e;
        int k;
        fm = (one << fw) - 1;
        em = (one << ew) - 1;
        ex = (x >> fw) & em;
        ey = (y >> fw) & em;
        fx = x & fm;
        fy = y & fm;
        s = x[ew+fw] ^ y[ew+fw];
        sg = {63'b0, s} << (ew + fw);
        xz = ex == 0; yz = ey == 0;
        xi = ex == em && fx == 0; yi = ey == em && fy == 0;
        xn = ex == em && fx != 0; yn = ey == em && fy != 0;
        r.ov = 0; r.un = 0;
        if (xn || yn || (xi && yz) || (yi && xz)) r.z = (em << fw) | (one << (fw - 1));
        else if (xi || yi) r.z = sg | (em << fw);
        else if (xz || yz) r.z = sg;
        else begin
            p = ((one << fw) | fx) * ((one << fw) | fy);
            k = p >= (one << (2 * fw + 1)) ? fw + 1 : fw;
            q = p >> k;
            rem = p & ((one << k) - 1);
            half = one << (k - 1);
            case (m)
                3'd1: up = 0;
                3'd2: up = s && rem != 0;
                3'd3: up = !s && rem != 0;
                3'd4: up = rem >= half;
                default: up = rem > half || (rem == half && q[0]);
            endcase
            q = q + {63'b0, up};
            e = longint'(ex) + longint'(ey) - ((longint'(1) << (ew - 1)) - 1) + longint'(k - fw);
            if ((q >> (fw + 1)) != 0) begin q = q >> 1; e++; end
            if (e >= longint'(em)) begin
                r.ov = 1;
                to_max = m == 3'd1 || (m == 3'd2 && !s) || (m == 3'd3 && s);
                r.z = sg | (to_max ? (((em - 1) << fw) | fm) : (em << fw));
            end else if (e <= 0) begin
                r.un = 1;
                r.z = sg;
            end else r.z = sg | (64'(e) << fw) | (q & fm);
        end
        return r;
    endfunction

    function automatic bit [31:0] rnd_op();
        bit [31:0] v = $urandom;
        int c = $urandom_range(0, 9);
        if (c == 0) v[30:23] = 8'h00;
        else if (c == 1) v[30:23] = 8'hFF;
        else if (c == 2) begin v[30:23] = 8'hFF; v[22:0] = '0; end
        else if (c == 3) v[30:23] = 8'($urandom_range(190, 254));
        else if (c == 4) v[30:23] = 8'($urandom_range(1, 40));
        else v[30:23] = 8'($urandom_range(100, 155));
        return v;
    endfunction

    // One cycle: drive at negedge, sample after settling, well before the rising edge
    task automatic step(input bit iv, input bit [31:0] x, input bit [31:0] y, input bit [2:0] m,
                        input bit ordy, output bit acc);
        res_t e;
        in_valid = iv; fp_X = x; fp_Y = y; r_mode = m; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && !out_ready) begin
            n_stall++;
            chk("in_ready_stall", in_ready, 0);
            if (was_stall) chk("hold_out", {ovrf, udrf, fp_Z}, held);
            held = {ovrf, udrf, fp_Z};
            was_stall = 1;
        end else was_stall = 0;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("fp_Z", fp_Z, e.z);
                chk("ovrf", ovrf, e.ov);
                chk("udrf", udrf, e.un);
                n_ret++;
            end
        end
        if (acc) sb.push_back(use_dir ? dir_e : ref_mul(x, y, m, 8, 23));
        @(negedge clk);
    endtask

    task automatic send(input bit [31:0] x, input bit [31:0] y, input bit [2:0] m, input bit ordy);
        bit a = 0;
        int t = 0;
        while (!a && t < 50) begin step(1, x, y, m, ordy, a); t++; end
        if (!a) chk("accept_timeout", a, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        bit a;
        int t = 0;
        while (sb.size() != 0 && t < 40) begin step(0, 0, 0, 0, 1, a); t++; end
        chk("drain", sb.size(), 0);
    endtask

    task automatic dir(input bit [31:0] x, input bit [31:0] y, input bit [2:0] m,
                       input bit [31:0] ez, input bit eo, input bit eu);
        use_dir = 1;
        dir_e.z = {32'b0, ez}; dir_e.ov = eo; dir_e.un = eu;
        send(x, y, m, 1);
        use_dir = 0;
        drain();
    endtask

    task automatic hop(input bit [15:0] x, input bit [15:0] y, input bit [2:0] m, input res_t e);
        int t = 0;
        h_x = x; h_y = y; h_m = m; h_iv = 1;
        #1 chk("h_ready", h_ir, 1);
        @(negedge clk);
        h_iv = 0;
        while (!h_ov && t < 10) begin @(negedge clk); t++; end
        chk("h_valid", h_ov, 1);
        chk("h_z", h_z, e.z);
        chk("h_flags", {h_ovf, h_udf}, {e.ov, e.un});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        bit a;
        int lat, idx, r0, s0, seen;
        bit [31:0] ox[6], oy[6];
        res_t he;
        bit [15:0] hx, hy;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fp_Z", fp_Z, 0);
        chk("rst_flags", {ovrf, udrf}, 0);
        rst_n = 1;
        @(negedge clk);
        #1 chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        use_dir = 1;
        dir_e.z = 64'h40400000; dir_e.ov = 0; dir_e.un = 0;
        step(1, 32'h3FC00000, 32'h40000000, 0, 1, a);
        use_dir = 0;
        chk("lat_accept", a, 1);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
        chk("latency", lat, 3);
        drain();

        dir(32'h00000001, 32'h3F800000, 0, 32'h00000000, 0, 0);
        dir(32'h80000000, 32'h40400000, 0, 32'h80000000, 0, 0);
        dir(32'h7F7FFFFF, 32'h40000000, 0, 32'h7F800000, 1, 0);
        dir(32'h7F7FFFFF, 32'h40000000, 1, 32'h7F7FFFFF, 1, 0);
        dir(32'hFF7FFFFF, 32'h40000000, 3, 32'hFF7FFFFF, 1, 0);
        dir(32'hFF7FFFFF, 32'h40000000, 2, 32'hFF800000, 1, 0);
        dir(32'h7F7FFFFF, 32'h40000000, 2, 32'h7F7FFFFF, 1, 0);
        dir(32'h7F7FFFFF, 32'h40000000, 3, 32'h7F800000, 1, 0);
        dir(32'h7F800000, 32'h00000000, 0, 32'h7FC00000, 0, 0);
        dir(32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 0, 0);
        dir(32'h7F800000, 32'hC0000000, 0, 32'hFF800000, 0, 0);
        dir(32'h00800000, 32'h3F000000, 0, 32'h00000000, 0, 1);
        dir(32'h00800000, 32'h3F800000, 0, 32'h00800000, 0, 0);
        dir(32'h3F800001, 32'h3F800001, 3, 32'h3F800003, 0, 0);
        dir(32'h3F800001, 32'h3F800001, 1, 32'h3F800002, 0, 0);
        dir(32'h3F800003, 32'h3FC00000, 0, 32'h3FC00004, 0, 0);
        dir(32'h3F800003, 32'h3FC00000, 4, 32'h3FC00005, 0, 0);
        dir(32'h3F800003, 32'h3FC00000, 7, 32'h3FC00004, 0, 0);
        dir(32'hBF800003, 32'h3FC00000, 2, 32'hBFC00005, 0, 0);
        dir(32'h3FFFFFFE, 32'h3F800001, 0, 32'h40000000, 0, 0);
        dir(32'h3FFFFFFE, 32'h3F800001, 1, 32'h3FFFFFFF, 0, 0);

        for (int i = 0; i < 5; i++) begin ox[i] = rnd_op(); oy[i] = rnd_op(); end
        ox[5] = 0; oy[5] = 0;
        idx = 0; r0 = n_ret; s0 = n_stall;
        for (int c = 0; c < 40 && (idx < 5 || sb.size() != 0); c++) begin
            step(idx < 5, ox[idx], oy[idx], 0, c >= 8, a);
            if (a) idx++;
        end
        chk("bp_retired", n_ret - r0, 5);
        chk("bp_stall_cycles", n_stall - s0, 4);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 4) != 0, rnd_op(), rnd_op(), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7, a);
        in_valid = 0;
        drain();

        for (int i = 0; i < 3; i++) step(1, rnd_op(), rnd_op(), 0, 1, a);
        in_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_fp_Z", fp_Z, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (10) begin @(negedge clk); seen += int'(out_valid); end
        chk("no_stale", seen, 0);

        he.z = 64'h4200; he.ov = 0; he.un = 0;
        hop(16'h3E00, 16'h4000, 0, he);
        for (int i = 0; i < 60; i++) begin
            hx = 16'($urandom); hy = 16'($urandom);
            if (i % 4 != 0) begin hx[14:10] = 5'($urandom_range(8, 22)); hy[14:10] = 5'($urandom_range(8, 22)); end
            r_mode = 3'($urandom_range(0, 7));
            hop(hx, hy, r_mode, ref_mul({48'b0, hx}, {48'b0, hy}, r_mode, 5, 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
